// File: rtl/sprite_engine.sv
// Per-line sprite evaluator: scans the attribute table during horizontal blank
// into a shadow slot set, then draws from the active set copied at line start.
module sprite_engine #(
   parameter int unsigned NUM_SPRITES  = 32,
   parameter int unsigned MAX_PER_LINE = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        line_start,
   input  logic [7:0]  line_y,
   input  logic [13:0] sprite_attr_addr,
   input  logic [13:0] sprite_pattern_table_addr,
   input  logic        size16,
   input  logic        mag,
   output logic [13:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_data,
   input  logic [7:0]  pix_x,
   input  logic        pix_valid,
   output logic [3:0]  pix_color,
   output logic        fifth_flag,
   output logic [4:0]  fifth_num,
   output logic        collision,
   input  logic        status_rd,
   output logic        busy
);

   localparam int unsigned AW        = 14;
   localparam int unsigned SLOTS     = 8;
   localparam logic [7:0]  Y_TERM    = 8'd208;

   typedef enum logic [2:0] {IDLE, SCAN, ATTR, PAT, DONE} state_e;

   typedef struct packed {
      logic        vld;
      logic [7:0]  x;
      logic [3:0]  col;
      logic [15:0] pat;   // leftmost pixel in bit 15; 8x8 rows use [15:8]
   } slot_t;

   state_e      state_q, state_d;
   logic [1:0]  sub_q, sub_d;
   logic [4:0]  n_q, n_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  line_y_q, line_y_d;
   logic [7:0]  row_q, row_d;
   logic [7:0]  x_q, x_d;
   logic [3:0]  col_q, col_d;
   logic [15:0] pat_q, pat_d;
   logic [13:0] mem_addr_q, mem_addr_d;
   logic        mem_rd_q, mem_rd_d;
   logic        busy_q;
   logic        fifth_q, collision_q;
   logic [4:0]  fifth_num_q;
   logic [3:0]  pix_color_q;
   slot_t       shadow_q [SLOTS];
   slot_t       active_q [SLOTS];

   logic        fifth_set_c, slot_we_c, fin_c, last_c, vis_c;
   slot_t       slot_wd_c;
   logic [7:0]  row_c, h_c, name_c;
   logic [3:0]  r_c;
   logic [13:0] next_entry_c;

   // Next-state logic; read requests are prepared one cycle ahead so they leave a register
   always_comb begin
      state_d     = state_q;
      sub_d       = sub_q;
      n_d         = n_q;
      cnt_d       = cnt_q;
      line_y_d    = line_y_q;
      row_d       = row_q;
      x_d         = x_q;
      col_d       = col_q;
      pat_d       = pat_q;
      mem_rd_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      fifth_set_c = 1'b0;
      slot_we_c   = 1'b0;
      slot_wd_c   = '0;
      fin_c       = 1'b0;
      last_c       = (n_q == 5'(NUM_SPRITES - 1));
      next_entry_c = sprite_attr_addr + AW'({n_q + 5'd1, 2'b00});
      row_c        = line_y_q - mem_data - 8'd1;
      case ({size16, mag})
         2'b00:   h_c = 8'd8;
         2'b11:   h_c = 8'd32;
         default: h_c = 8'd16;
      endcase
      vis_c  = (row_c < h_c);
      name_c = size16 ? (mem_data & 8'hFC) : mem_data;
      r_c    = 4'(row_q >> mag);

      case (state_q)
         SCAN: begin
            if (sub_q == 2'd0) begin
               sub_d = 2'd1;
            end else begin
               sub_d = 2'd0;
               if (mem_data == Y_TERM) begin
                  state_d = DONE;
               end else if (vis_c && (cnt_q < 4'(MAX_PER_LINE))) begin
                  state_d    = ATTR;
                  row_d      = row_c;
                  mem_rd_d   = 1'b1;
                  mem_addr_d = mem_addr_q + AW'(1);
               end else if (vis_c) begin
                  fifth_set_c = 1'b1;
                  state_d     = DONE;
               end else if (last_c) begin
                  state_d = DONE;
               end else begin
                  n_d        = n_q + 5'd1;
                  mem_rd_d   = 1'b1;
                  mem_addr_d = next_entry_c;
               end
            end
         end
         ATTR: begin
            if (sub_q == 2'd2) begin
               state_d    = PAT;
               sub_d      = 2'd0;
               mem_rd_d   = 1'b1;
               mem_addr_d = sprite_pattern_table_addr + AW'({name_c, 3'b000}) + AW'(r_c);
            end else begin
               if (sub_q == 2'd1) x_d = mem_data;
               sub_d      = sub_q + 2'd1;
               mem_rd_d   = 1'b1;
               mem_addr_d = mem_addr_q + AW'(1);
            end
         end
         PAT: begin
            case (sub_q)
               2'd0: begin
                  col_d = mem_data[3:0];
                  sub_d = 2'd1;
                  if (size16) begin
                     mem_rd_d   = 1'b1;
                     mem_addr_d = mem_addr_q + AW'(16);
                  end
               end
               2'd1: begin
                  pat_d = {mem_data, 8'h00};
                  if (size16) sub_d = 2'd2;
                  else        fin_c = 1'b1;
               end
               default: begin
                  pat_d = {pat_q[15:8], mem_data};
                  fin_c = 1'b1;
               end
            endcase
            if (fin_c) begin
               slot_we_c = 1'b1;
               slot_wd_c = '{vld: 1'b1, x: x_q, col: col_q, pat: pat_d};
               cnt_d     = cnt_q + 4'd1;
               sub_d     = 2'd0;
               if (last_c) begin
                  state_d = DONE;
               end else begin
                  state_d    = SCAN;
                  n_d        = n_q + 5'd1;
                  mem_rd_d   = 1'b1;
                  mem_addr_d = next_entry_c;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (line_start) begin
         state_d     = SCAN;
         sub_d       = 2'd0;
         n_d         = 5'd0;
         cnt_d       = 4'd0;
         line_y_d    = line_y;
         mem_rd_d    = 1'b1;
         mem_addr_d  = sprite_attr_addr;
         slot_we_c   = 1'b0;
         fifth_set_c = 1'b0;
      end
   end

   // Evaluation state and read-request registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         sub_q      <= '0;
         n_q        <= '0;
         cnt_q      <= '0;
         line_y_q   <= '0;
         row_q      <= '0;
         x_q        <= '0;
         col_q      <= '0;
         pat_q      <= '0;
         mem_addr_q <= '0;
         mem_rd_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sub_q      <= sub_d;
         n_q        <= n_d;
         cnt_q      <= cnt_d;
         line_y_q   <= line_y_d;
         row_q      <= row_d;
         x_q        <= x_d;
         col_q      <= col_d;
         pat_q      <= pat_d;
         mem_addr_q <= mem_addr_d;
         mem_rd_q   <= mem_rd_d;
         busy_q     <= (state_d != IDLE);
      end
   end

   // Slot sets: shadow fills during evaluation, becomes active at line start
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < SLOTS; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else if (line_start) begin
         for (int unsigned i = 0; i < SLOTS; i++) begin
            active_q[i] <= shadow_q[i];
            shadow_q[i] <= '0;
         end
      end else if (slot_we_c) begin
         shadow_q[cnt_q[2:0]] <= slot_wd_c;
      end
   end

   logic [7:0] wid_c, d_c, c_c;
   logic       hit_c, any_c, coll_c;
   logic [3:0] win_c;

   // Pixel hit test: lowest slot wins, any second hit flags a collision
   always_comb begin
      wid_c  = size16 ? 8'd16 : 8'd8;
      d_c    = '0;
      c_c    = '0;
      hit_c  = 1'b0;
      any_c  = 1'b0;
      coll_c = 1'b0;
      win_c  = '0;
      for (int unsigned i = 0; i < MAX_PER_LINE; i++) begin
         d_c   = pix_x - active_q[3'(i)].x;
         c_c   = d_c >> mag;
         hit_c = active_q[3'(i)].vld && (c_c < wid_c) &&
                 active_q[3'(i)].pat[4'd15 - c_c[3:0]];
         if (hit_c) begin
            if (any_c) coll_c = 1'b1;
            else       win_c  = active_q[3'(i)].col;
            any_c = 1'b1;
         end
      end
   end

   // Registered pixel colour and sticky status flags (a set beats a clear)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pix_color_q <= '0;
         collision_q <= 1'b0;
         fifth_q     <= 1'b0;
         fifth_num_q <= '0;
      end else begin
         pix_color_q <= pix_valid ? win_c : 4'd0;
         if (pix_valid && coll_c) collision_q <= 1'b1;
         else if (status_rd)      collision_q <= 1'b0;
         if (fifth_set_c) begin
            fifth_q     <= 1'b1;
            fifth_num_q <= n_q;
         end else if (status_rd) begin
            fifth_q <= 1'b0;
         end
      end
   end

   assign mem_addr   = mem_addr_q;
   assign mem_rd     = mem_rd_q;
   assign busy       = busy_q;
   assign pix_color  = pix_color_q;
   assign collision  = collision_q;
   assign fifth_flag = fifth_q;
   assign fifth_num  = fifth_num_q;

endmodule

// File: tb/tb_sprite_engine.sv
// Directed bench for sprite_engine: VRAM model, scene setup and pixel vector tables.
module tb_sprite_engine;

   localparam int unsigned NS  = 32;
   localparam int unsigned MPL = 4;
   localparam logic [13:0] ATTR_BASE = 14'h1000;
   localparam logic [13:0] PAT_BASE  = 14'h3FE0;

   logic        clk = 1'b0;
   logic        reset, line_start, size16, mag, pix_valid, status_rd;
   logic [7:0]  line_y, pix_x, mem_data;
   logic [13:0] attr_addr, pat_addr, mem_addr;
   logic        mem_rd, fifth_flag, collision, busy;
   logic [4:0]  fifth_num;
   logic [3:0]  pix_color;

   always #5 clk = ~clk;

   sprite_engine #(.NUM_SPRITES(NS), .MAX_PER_LINE(MPL)) dut (
      .clk(clk), .reset(reset), .line_start(line_start), .line_y(line_y),
      .sprite_attr_addr(attr_addr), .sprite_pattern_table_addr(pat_addr),
      .size16(size16), .mag(mag), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_data(mem_data), .pix_x(pix_x), .pix_valid(pix_valid),
      .pix_color(pix_color), .fifth_flag(fifth_flag), .fifth_num(fifth_num),
      .collision(collision), .status_rd(status_rd), .busy(busy)
   );

   // VRAM: data one cycle after the request; every request address is logged
   logic [7:0]  vram [16384];
   logic [13:0] rlog [1024];
   int          nreads = 0;
   always @(posedge clk) begin
      if (mem_rd) begin
         mem_data <= vram[mem_addr];
         if (nreads < 1024) rlog[nreads] <= mem_addr;
         nreads <= nreads + 1;
      end
   end

   typedef struct {
      int         sc;
      logic [7:0] x;
      logic       v;
      logic       srd;
      logic [3:0] col;
      logic       coll;
   } vec_t;

   vec_t vt [64];
   int   nvec = 0;
   int   n_cmp = 0, n_fail = 0;

   task automatic add(input int sc, input int x, input int v, input int srd,
                      input int col, input int coll);
      vt[nvec] = '{sc, 8'(x), 1'(v), 1'(srd), 4'(col), 1'(coll)};
      nvec++;
   endtask

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_sprite(input int idx, input int y, input int x,
                             input int nm, input int cb);
      vram[14'(int'(ATTR_BASE) + 4*idx + 0)] = 8'(y);
      vram[14'(int'(ATTR_BASE) + 4*idx + 1)] = 8'(x);
      vram[14'(int'(ATTR_BASE) + 4*idx + 2)] = 8'(nm);
      vram[14'(int'(ATTR_BASE) + 4*idx + 3)] = 8'(cb);
   endtask

   task automatic set_pat(input int off, input int b);
      vram[14'(int'(PAT_BASE) + off)] = 8'(b);
   endtask

   task automatic clear_table();
      for (int i = 0; i < 32; i++) set_sprite(i, 8'hC0, 0, 0, 0);
   endtask

   task automatic do_line(input int ly, output int cyc);
      @(negedge clk); line_start = 1'b1; line_y = 8'(ly);
      @(negedge clk); line_start = 1'b0; cyc = 1;
      while (busy && cyc < 400) begin
         @(negedge clk); cyc++;
      end
      check($sformatf("line%0d_busy_done", ly), int'(busy), 0);
   endtask

   task automatic clear_status();
      @(negedge clk); status_rd = 1'b1; pix_valid = 1'b0;
      @(negedge clk); status_rd = 1'b0;
   endtask

   task automatic run_vecs(input int sc);
      for (int i = 0; i < nvec; i++) begin
         if (vt[i].sc == sc) begin
            @(negedge clk);
            pix_x = vt[i].x; pix_valid = vt[i].v; status_rd = vt[i].srd;
            @(posedge clk); #1;
            check($sformatf("s%0d_x%0d_color", sc, vt[i].x), int'(pix_color), int'(vt[i].col));
            check($sformatf("s%0d_x%0d_coll", sc, vt[i].x), int'(collision), int'(vt[i].coll));
         end
      end
      @(negedge clk); pix_valid = 1'b0; status_rd = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pix_color"}, int'(pix_color), 0);
      check({tag, "_mem_rd"}, int'(mem_rd), 0);
      check({tag, "_mem_addr"}, int'(mem_addr), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_fifth_flag"}, int'(fifth_flag), 0);
      check({tag, "_fifth_num"}, int'(fifth_num), 0);
      check({tag, "_collision"}, int'(collision), 0);
   endtask

   int cyc, b, k;

   initial begin
      // scene 1: 8x8, overlap and early terminator
      add(1, 19, 1, 0, 0, 0);  add(1, 20, 1, 0, 5, 0);  add(1, 21, 1, 0, 0, 0);
      add(1, 27, 1, 0, 5, 0);  add(1, 28, 1, 0, 0, 0);  add(1, 48, 1, 0, 3, 0);
      add(1, 20, 0, 0, 0, 0);  add(1, 50, 1, 0, 3, 1);  add(1, 54, 1, 0, 3, 1);
      add(1, 56, 1, 0, 0, 1);  add(1, 0, 0, 1, 0, 0);   add(1, 51, 1, 1, 3, 1);
      add(1, 0, 0, 1, 0, 0);   add(1, 100, 1, 0, 0, 0);
      // scene 2: slot overflow, only four drawn
      add(2, 0, 1, 0, 1, 0);   add(2, 3, 1, 0, 1, 0);   add(2, 17, 1, 0, 2, 0);
      add(2, 18, 1, 0, 0, 0);  add(2, 20, 1, 0, 6, 0);  add(2, 37, 1, 0, 7, 0);
      add(2, 40, 1, 0, 0, 0);  add(2, 47, 1, 0, 0, 0);  add(2, 60, 1, 0, 0, 0);
      // scene 4: 16x16 magnified, transparent winner
      add(4, 59, 1, 0, 0, 0);  add(4, 60, 1, 0, 12, 0); add(4, 61, 1, 0, 12, 0);
      add(4, 62, 1, 0, 0, 0);  add(4, 64, 1, 0, 12, 0); add(4, 65, 1, 0, 12, 0);
      add(4, 90, 1, 0, 12, 0); add(4, 91, 1, 0, 12, 0); add(4, 92, 1, 0, 0, 0);
      add(4, 196, 1, 0, 3, 0); add(4, 200, 1, 0, 0, 1);
      // scene 5: first line after reset is empty; scene 6: following line draws again
      add(5, 20, 1, 0, 0, 0);  add(5, 50, 1, 0, 0, 0);
      add(6, 20, 1, 0, 5, 0);  add(6, 27, 1, 0, 5, 0);

      for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
      reset = 1'b1; line_start = 1'b0; line_y = '0; size16 = 1'b0; mag = 1'b0;
      pix_x = '0; pix_valid = 1'b0; status_rd = 1'b0;
      attr_addr = ATTR_BASE; pat_addr = PAT_BASE;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;

      // scene 1
      clear_table();
      set_sprite(0, 9, 20, 0, 5);
      set_sprite(1, 9, 48, 1, 3);
      set_sprite(2, 9, 50, 2, 8);
      set_sprite(3, 208, 0, 0, 0);
      set_sprite(4, 9, 100, 1, 7);
      set_pat(0, 8'h81); set_pat(8, 8'hFF); set_pat(16, 8'hF0);
      clear_status();
      b = nreads;
      do_line(10, cyc);
      check("s1_reads", nreads - b, 16);
      check("s1_last_addr", int'(rlog[nreads-1]), int'(ATTR_BASE) + 12);
      check("s1_pat_addr", int'(rlog[b+4]), int'(PAT_BASE));
      check("s1_fifth", int'(fifth_flag), 0);
      do_line(11, cyc);
      run_vecs(1);

      // scene 2
      clear_table();
      set_sprite(0, 39, 0, 3, 1);
      set_sprite(1, 32, 10, 3, 2);
      set_sprite(2, 31, 60, 3, 4);
      set_sprite(3, 39, 20, 3, 6);
      set_sprite(4, 39, 30, 3, 7);
      set_sprite(5, 39, 40, 3, 9);
      for (int i = 24; i < 32; i++) set_pat(i, 8'hFF);
      clear_status();
      b = nreads;
      do_line(40, cyc);
      check("s2_reads", nreads - b, 22);
      check("s2_fifth_flag", int'(fifth_flag), 1);
      check("s2_fifth_num", int'(fifth_num), 5);
      do_line(41, cyc);
      run_vecs(2);
      check("s2_fifth_held", int'(fifth_flag), 1);
      clear_status();
      check("s2_fifth_cleared", int'(fifth_flag), 0);

      // scene 3: terminator at entry 0
      clear_table();
      set_sprite(0, 208, 0, 0, 0);
      b = nreads;
      do_line(10, cyc);
      check("y208_reads", nreads - b, 1);
      check("y208_busy_within_8", int'(cyc <= 8), 1);

      // full scan, nothing visible
      clear_table();
      b = nreads;
      do_line(10, cyc);
      check("scan_reads", nreads - b, 32);
      check("scan_last_addr", int'(rlog[nreads-1]), int'(ATTR_BASE) + 124);
      check("scan_cycles", int'(cyc <= 2*32 + 6*4 + 2), 1);

      // scene 4: pattern addresses wrap past the top of VRAM
      clear_table();
      size16 = 1'b1; mag = 1'b1;
      set_sprite(0, 100, 200, 8'h05, 8'hF0);
      set_sprite(1, 100, 60, 8'h05, 8'hFC);
      set_sprite(2, 100, 196, 8'h05, 8'h03);
      set_sprite(3, 208, 0, 0, 0);
      set_pat(35, 8'hA0); set_pat(51, 8'h01);
      clear_status();
      b = nreads;
      do_line(107, cyc);
      check("s4_reads", nreads - b, 19);
      check("s4_pat_left_addr", int'(rlog[b+4]), 14'h0003);
      check("s4_pat_right_addr", int'(rlog[b+5]), 14'h0013);
      do_line(108, cyc);
      run_vecs(4);

      // reset during PAT
      size16 = 1'b0; mag = 1'b0;
      clear_table();
      set_sprite(0, 9, 20, 0, 5);
      set_sprite(1, 9, 48, 1, 3);
      set_sprite(2, 9, 50, 2, 8);
      set_sprite(3, 208, 0, 0, 0);
      do_line(10, cyc);
      do_line(11, cyc);
      @(negedge clk); pix_x = 8'd50; pix_valid = 1'b1;
      @(posedge clk); #1;
      check("pre_reset_color", int'(pix_color), 3);
      check("pre_reset_coll", int'(collision), 1);
      @(negedge clk); line_start = 1'b1; line_y = 8'd10;
      @(negedge clk); line_start = 1'b0; k = 0;
      while (!(mem_rd && mem_addr >= PAT_BASE) && k < 50) begin
         @(negedge clk); k++;
      end
      check("pat_reached", int'(k < 50), 1);
      reset = 1'b1;
      #1;
      check_all_zero("pat_reset");
      pix_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      do_line(10, cyc);
      run_vecs(5);
      do_line(11, cyc);
      run_vecs(6);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 1, expected 0");
      $fatal(1, "timeout");
   end

endmodule
